// File: rtl/app_mem_if.sv
// MIG-style app_* command/write-data/read-data bundle shared by the responder and its driver.
interface app_mem_if #(
  parameter int unsigned MEM_DATA_BITS    = 256,
  parameter int unsigned MEM_IF_ADDR_BITS = 29
);
  logic [MEM_IF_ADDR_BITS-1:0] app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic                        app_rdy;
  logic [MEM_DATA_BITS-1:0]    app_wdf_data;
  logic [MEM_DATA_BITS/8-1:0]  app_wdf_mask;
  logic                        app_wdf_wren;
  logic                        app_wdf_end;
  logic                        app_wdf_rdy;
  logic [MEM_DATA_BITS-1:0]    app_rd_data;
  logic                        app_rd_data_valid;
  logic                        app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/app_mem_responder.sv
// BRAM-backed stand-in for the DDR3 controller's app_* interface: in-order command execution,
// fixed-latency reads. Define APP_RESP_RANDOM_STALL_EN to add LFSR-driven ready stalls.
module app_mem_responder #(
  parameter int unsigned MEM_DATA_BITS    = 256,
  parameter int unsigned MEM_IF_ADDR_BITS = 29,
  parameter int unsigned DEPTH_BITS       = 8,
  parameter int unsigned RD_LATENCY       = 4,
  parameter int unsigned CALIB_CYCLES     = 64
) (
  input  logic      mem_clk,
  input  logic      rst,
  output logic      init_calib_complete,
  app_mem_if.slave  app
);
  localparam int unsigned MASK_BITS  = MEM_DATA_BITS / 8;
  localparam int unsigned WORDS      = 1 << DEPTH_BITS;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned CAL_W      = $clog2(CALIB_CYCLES + 1);
  localparam logic [2:0]  CMD_WR     = 3'b000;
  localparam logic [2:0]  CMD_RD     = 3'b001;

  logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
  logic              calib_q, calib_d;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d, dat_cnt_q, dat_cnt_d;
  logic [PTR_W-1:0]  cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [PTR_W-1:0]  dat_wp_q, dat_wp_d, dat_rp_q, dat_rp_d;

  logic [2:0]               cmd_op_q  [FIFO_DEPTH];
  logic [DEPTH_BITS-1:0]    cmd_idx_q [FIFO_DEPTH];
  logic [MEM_DATA_BITS-1:0] wd_data_q [FIFO_DEPTH];
  logic [MASK_BITS-1:0]     wd_mask_q [FIFO_DEPTH];
  logic [MEM_DATA_BITS-1:0] mem_q     [WORDS];

  logic [RD_LATENCY:0]      rd_vld_q;
  logic [MEM_DATA_BITS-1:0] rd_dat_q  [RD_LATENCY+1];

  logic stall_c, rdy_ok_c, app_rdy_c, wdf_rdy_c;
  logic cmd_push_c, dat_push_c, exec_c, wr_exec_c, rd_exec_c;
  logic [2:0]            head_op_c;
  logic [DEPTH_BITS-1:0] head_idx_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{app.app_addr[2:0], app.app_addr[MEM_IF_ADDR_BITS-1:DEPTH_BITS+3]};

`ifdef APP_RESP_RANDOM_STALL_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; low two bits == 0 blank both ready outputs
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall_c = (lfsr_q[1:0] == 2'b00);
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign stall_c = 1'b0;
`endif

  // Handshake, head decode and FIFO/calibration next state
  always_comb begin
    rdy_ok_c   = calib_q && !stall_c;
    app_rdy_c  = rdy_ok_c && (cmd_cnt_q < CNT_W'(FIFO_DEPTH));
    wdf_rdy_c  = rdy_ok_c && (dat_cnt_q < CNT_W'(FIFO_DEPTH));
    cmd_push_c = app.app_en && app_rdy_c;
    dat_push_c = app.app_wdf_wren && wdf_rdy_c;
    head_op_c  = cmd_op_q[cmd_rp_q];
    head_idx_c = cmd_idx_q[cmd_rp_q];
    exec_c     = (cmd_cnt_q != '0) && ((head_op_c != CMD_WR) || (dat_cnt_q != '0));
    wr_exec_c  = exec_c && (head_op_c == CMD_WR);
    rd_exec_c  = exec_c && (head_op_c == CMD_RD);

    cal_cnt_d = cal_cnt_q;
    calib_d   = calib_q;
    if (!calib_q) begin
      cal_cnt_d = cal_cnt_q + CAL_W'(1);
      if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
    end

    cmd_cnt_d = cmd_cnt_q + CNT_W'(cmd_push_c) - CNT_W'(exec_c);
    cmd_wp_d  = cmd_wp_q + PTR_W'(cmd_push_c);
    cmd_rp_d  = cmd_rp_q + PTR_W'(exec_c);
    dat_cnt_d = dat_cnt_q + CNT_W'(dat_push_c) - CNT_W'(wr_exec_c);
    dat_wp_d  = dat_wp_q + PTR_W'(dat_push_c);
    dat_rp_d  = dat_rp_q + PTR_W'(wr_exec_c);
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
      cmd_cnt_q <= '0;
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      dat_cnt_q <= '0;
      dat_wp_q  <= '0;
      dat_rp_q  <= '0;
    end else begin
      cal_cnt_q <= cal_cnt_d;
      calib_q   <= calib_d;
      cmd_cnt_q <= cmd_cnt_d;
      cmd_wp_q  <= cmd_wp_d;
      cmd_rp_q  <= cmd_rp_d;
      dat_cnt_q <= dat_cnt_d;
      dat_wp_q  <= dat_wp_d;
      dat_rp_q  <= dat_rp_d;
    end
  end

  // FIFO payloads and storage are never reset; occupancy counters gate their use
  always_ff @(posedge mem_clk) begin
    if (cmd_push_c) begin
      cmd_op_q[cmd_wp_q]  <= app.app_cmd;
      cmd_idx_q[cmd_wp_q] <= app.app_addr[DEPTH_BITS+2:3];
    end
    if (dat_push_c) begin
      wd_data_q[dat_wp_q] <= app.app_wdf_data;
      wd_mask_q[dat_wp_q] <= app.app_wdf_mask;
    end
    if (wr_exec_c) begin
      for (int b = 0; b < int'(MASK_BITS); b++) begin
        if (!wd_mask_q[dat_rp_q][b]) mem_q[head_idx_c][b*8 +: 8] <= wd_data_q[dat_rp_q][b*8 +: 8];
      end
    end
  end

  // Storage read at execution, then RD_LATENCY shift stages to the outputs
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= '0;
      for (int i = 0; i <= int'(RD_LATENCY); i++) rd_dat_q[i] <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[RD_LATENCY-1:0], rd_exec_c};
      if (rd_exec_c) rd_dat_q[0] <= mem_q[head_idx_c];
      for (int i = 1; i <= int'(RD_LATENCY); i++) rd_dat_q[i] <= rd_dat_q[i-1];
    end
  end

  assign init_calib_complete   = calib_q;
  assign app.app_rdy           = app_rdy_c;
  assign app.app_wdf_rdy       = wdf_rdy_c;
  assign app.app_rd_data       = rd_dat_q[RD_LATENCY];
  assign app.app_rd_data_valid = rd_vld_q[RD_LATENCY];
  assign app.app_rd_data_end   = rd_vld_q[RD_LATENCY];

`ifndef SYNTHESIS
  wdf_end_chk: assert property (@(posedge mem_clk) disable iff (rst)
                                (app.app_wdf_wren && wdf_rdy_c) |-> app.app_wdf_end)
    else $error("app_wdf_wren accepted with app_wdf_end low");
`endif
endmodule

// File: tb/tb_app_mem_responder.sv
// Self-checking bench for app_mem_responder: directed scenarios plus randomized traffic
// checked against an in-order word-array reference model.
`timescale 1ns/1ps
module tb_app_mem_responder;
  localparam int unsigned DW  = 256;
  localparam int unsigned AW  = 29;
  localparam int unsigned DB  = 8;
  localparam int unsigned RDL = 4;
  localparam int unsigned CAL = 64;
  localparam int unsigned MB  = DW / 8;
  localparam int          TMO = 200;
  localparam logic [2:0]  WR  = 3'b000;
  localparam logic [2:0]  RD  = 3'b001;

  logic mem_clk = 1'b0;
  logic rst     = 1'b1;
  logic init_calib_complete;

  app_mem_if #(.MEM_DATA_BITS(DW), .MEM_IF_ADDR_BITS(AW)) app_if ();

  app_mem_responder #(
    .MEM_DATA_BITS(DW), .MEM_IF_ADDR_BITS(AW), .DEPTH_BITS(DB),
    .RD_LATENCY(RDL), .CALIB_CYCLES(CAL)
  ) dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .app                 (app_if)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
    int            lat;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ref_mem [2**DB];
  bit            written [2**DB];
  logic [DW-1:0] wd [5];
  logic [DW-1:0] last_rd;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            vld_seen = 0;

  always @(posedge mem_clk) cyc <= cyc + 1;

  task automatic apply_wr(input logic [DB-1:0] idx, input logic [DW-1:0] d, input logic [MB-1:0] m);
    for (int b = 0; b < int'(MB); b++) if (!m[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    written[idx] = 1'b1;
  endtask

  // Memory model: commands take effect in acceptance order; reads capture the word at that point
  task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MB-1:0] m, input int lat);
    int n = 0;
    logic [DB-1:0] idx;
    idx = a[DB+2:3];
    @(negedge mem_clk);
    app_if.app_en = 1'b1; app_if.app_cmd = c; app_if.app_addr = a;
    while (app_if.app_rdy !== 1'b1 && n < TMO) begin @(negedge mem_clk); n++; end
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL cmd_accept: app_rdy=%b after %0d cycles, required 1", app_if.app_rdy, n);
    end else begin
      @(posedge mem_clk);
      if (c == WR) apply_wr(idx, d, m);
      else if (c == RD) expq.push_back('{ref_mem[idx], cyc + 1, lat});
    end
    #1 app_if.app_en = 1'b0;
  endtask

  task automatic do_data(input logic [DW-1:0] d, input logic [MB-1:0] m);
    int n = 0;
    @(negedge mem_clk);
    app_if.app_wdf_wren = 1'b1; app_if.app_wdf_data = d; app_if.app_wdf_mask = m;
    app_if.app_wdf_end = 1'b1;
    while (app_if.app_wdf_rdy !== 1'b1 && n < TMO) begin @(negedge mem_clk); n++; end
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL data_accept: app_wdf_rdy=%b after %0d cycles, required 1", app_if.app_wdf_rdy, n);
    end else @(posedge mem_clk);
    #1 app_if.app_wdf_wren = 1'b0;
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MB-1:0] m);
    fork
      do_cmd(WR, a, d, m, -1);
      do_data(d, m);
    join
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < TMO) begin @(negedge mem_clk); n++; end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL read_drain: %0d reads still outstanding, required 0", expq.size());
    end
  endtask

  task automatic mon_loop();
    exp_t e;
    forever begin
      @(negedge mem_clk);
      if (app_if.app_rd_data_valid === 1'b1) begin
        vld_seen++;
        last_rd = app_if.app_rd_data;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: valid=1 with no read outstanding, required valid=0");
        end else begin
          e = expq.pop_front();
          if (app_if.app_rd_data !== e.data) begin
            errors++;
            $display("FAIL rd_data: got %h required %h", app_if.app_rd_data, e.data);
          end
          checks++;
          if (app_if.app_rd_data_end !== 1'b1) begin
            errors++;
            $display("FAIL rd_end: got %b required 1", app_if.app_rd_data_end);
          end
          if (e.lat >= 0) begin
            checks++;
            if (cyc - e.acc !== e.lat) begin
              errors++;
              $display("FAIL rd_latency: got %0d cycles required %0d", cyc - e.acc, e.lat);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic exp_on;
    rst = 1'b1;
    repeat (3) @(negedge mem_clk);
    checks++;
    if ({init_calib_complete, app_if.app_rdy, app_if.app_wdf_rdy, app_if.app_rd_data_valid,
         app_if.app_rd_data_end} !== 5'b0 || app_if.app_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: calib/rdy/wdf_rdy/valid/end=%b%b%b%b%b data=%h, required all 0",
               init_calib_complete, app_if.app_rdy, app_if.app_wdf_rdy,
               app_if.app_rd_data_valid, app_if.app_rd_data_end, app_if.app_rd_data);
    end
    rst = 1'b0;
    for (int j = 1; j <= int'(CAL) + 4; j++) begin
      @(negedge mem_clk);
      exp_on = (j >= int'(CAL));
      checks++;
      if ({init_calib_complete, app_if.app_rdy, app_if.app_wdf_rdy} !== {3{exp_on}}) begin
        errors++;
        $display("FAIL calib_cycle%0d: calib/rdy/wdf_rdy=%b%b%b required %b%b%b", j,
                 init_calib_complete, app_if.app_rdy, app_if.app_wdf_rdy, exp_on, exp_on, exp_on);
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = {32{8'h11}};
    wr_word(29'h8, d, '0);
    repeat (2) @(negedge mem_clk);
    do_cmd(RD, 29'h8, '0, '0, int'(RDL) + 1);
    wait_drain();
    checks++;
    if (last_rd !== d) begin
      errors++;
      $display("FAIL write_read: got %h required %h", last_rd, d);
    end
  endtask

  task automatic test_late_data();
    logic [DW-1:0] old_d, new_d;
    old_d = {8{32'hDEAD_BEEF}};
    new_d = {8{32'h0123_4567}};
    wr_word(29'h10, old_d, '0);
    fork
      begin
        do_cmd(WR, 29'h10, new_d, '0, -1);
        do_cmd(RD, 29'h10, '0, '0, -1);
      end
      begin
        repeat (3) @(negedge mem_clk);
        do_data(new_d, '0);
      end
    join
    wait_drain();
    checks++;
    if (last_rd !== new_d) begin
      errors++;
      $display("FAIL late_data: got %h required %h", last_rd, new_d);
    end
  endtask

  task automatic test_mask();
    logic [MB-1:0] m;
    logic [DW-1:0] exp_w;
    m     = {{(MB-1){1'b1}}, 1'b0};
    exp_w = {{(MB-1){8'hFF}}, 8'h00};
    wr_word(29'h18, '1, '0);
    wr_word(29'h18, '0, m);
    do_cmd(RD, 29'h18, '0, '0, -1);
    wait_drain();
    checks++;
    if (last_rd !== exp_w) begin
      errors++;
      $display("FAIL mask: got %h required %h", last_rd, exp_w);
    end
  endtask

  task automatic test_fifo_full();
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < int'(DW / 32); k++) wd[i][k*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) do_cmd(WR, AW'(32'h100 + i * 8), wd[i], '0, -1);
    for (int j = 0; j < 3; j++) begin
      @(negedge mem_clk);
      checks++;
      if (app_if.app_rdy !== 1'b0) begin
        errors++;
        $display("FAIL fifo_full_rdy%0d: app_rdy=%b required 0", j, app_if.app_rdy);
      end
    end
    fork
      do_cmd(WR, AW'(32'h120), wd[4], '0, -1);
      for (int i = 0; i < 5; i++) do_data(wd[i], '0);
    join
    while (app_if.app_rdy !== 1'b1 && n < 10) begin @(negedge mem_clk); n++; end
    checks++;
    if (app_if.app_rdy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_drain_rdy: app_rdy=%b required 1", app_if.app_rdy);
    end
    for (int i = 0; i < 5; i++) do_cmd(RD, AW'(32'h100 + i * 8), '0, '0, int'(RDL) + 1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) do_cmd(RD, AW'(32'h8 + (i % 3) * 8), '0, '0, int'(RDL) + 1);
    wait_drain();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DB-1:0] idx;
    logic [DW-1:0] d;
    logic [MB-1:0] m;
    int r;
    for (int t = 0; t < 80; t++) begin
      r   = int'($urandom_range(0, 9));
      idx = DB'($urandom_range(0, 15));
      a   = AW'($urandom);
      a[DB+2:3] = idx;
      if (r < 4 || !written[idx]) begin
        for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom;
        for (int k = 0; k < int'(MB / 32); k++) m[k*32 +: 32] = $urandom;
        if (!written[idx] || $urandom_range(0, 1) == 0) m = '0;
        fork
          do_cmd(WR, a, d, m, -1);
          begin
            repeat ($urandom_range(0, 3)) @(negedge mem_clk);
            do_data(d, m);
          end
        join
      end else if (r < 9) begin
        do_cmd(RD, a, '0, '0, -1);
      end else begin
        do_cmd(3'($urandom_range(2, 7)), a, '0, '0, -1);
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    int vs;
    do_cmd(RD, 29'h8, '0, '0, -1);
    do_cmd(RD, 29'h10, '0, '0, -1);
    @(negedge mem_clk);
    rst = 1'b1;
    expq.delete();
    vs = vld_seen;
    repeat (3) @(negedge mem_clk);
    rst = 1'b0;
    repeat (int'(CAL) + int'(RDL) + 5) @(negedge mem_clk);
    checks++;
    if (vld_seen !== vs) begin
      errors++;
      $display("FAIL reset_drop: %0d valid pulses after reset, required 0", vld_seen - vs);
    end
    checks++;
    if (init_calib_complete !== 1'b1) begin
      errors++;
      $display("FAIL recalib: init_calib_complete=%b required 1", init_calib_complete);
    end
    do_cmd(RD, 29'h100, '0, '0, int'(RDL) + 1);
    wait_drain();
    checks++;
    if (last_rd !== wd[0]) begin
      errors++;
      $display("FAIL reset_keep_mem: got %h required %h", last_rd, wd[0]);
    end
  endtask

  initial begin
    app_if.app_en = 1'b0; app_if.app_cmd = '0; app_if.app_addr = '0;
    app_if.app_wdf_wren = 1'b0; app_if.app_wdf_end = 1'b1;
    app_if.app_wdf_data = '0; app_if.app_wdf_mask = '0;
    fork
      mon_loop();
    join_none
    test_reset();
    test_write_read();
    test_late_data();
    test_mask();
    test_fifo_full();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    repeat (5) @(negedge mem_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/app_mem_responder.md
Name: app_mem_responder

Overview:
- BRAM-backed responder for the MIG 4:1 user (app_*) interface. It is the target end of the memory burst controller's command/data handshake.
- It stands in for the DDR3 controller, so the burst controller and memory tester can be simulated quickly or loop-back tested on chip without DDR3 calibration.
- It accepts commands and write data, commits them in order to internal storage, and returns read data after a fixed latency.

Parameters:
- MEM_DATA_BITS, 256, width of one app data word (2 x nCK_PER_CLK x 32).
- MEM_IF_ADDR_BITS, 29, app_addr width.
- DEPTH_BITS, 8, log2 of the number of storage words.
- RD_LATENCY, 4, cycles from read-command execution to app_rd_data_valid (minimum 1).
- CALIB_CYCLES, 64, cycles from reset release to init_calib_complete.

Ports:
- mem_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- init_calib_complete  out  1  model calibration done.
- app_addr  in  MEM_IF_ADDR_BITS  command address, in DDR column units.
- app_cmd  in  3  3'b000 = write, 3'b001 = read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  MEM_DATA_BITS  write data.
- app_wdf_mask  in  MEM_DATA_BITS/8  byte mask; 1 = byte NOT written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; always 1 in 4:1 mode.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  MEM_DATA_BITS  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.

Behaviour:
- Reset values: all outputs 0. Command FIFO, data FIFO, read pipeline and calibration counter are cleared. Storage contents are not cleared.
- Reset asserted mid-operation: in-flight reads are dropped with no valid pulse; queued writes are discarded.
- Calibration: a counter runs from reset release; init_calib_complete rises after CALIB_CYCLES cycles and stays high until rst. app_rdy and app_wdf_rdy are held 0 while it is low.
- Word index: app_addr[DEPTH_BITS+2:3]. Bits [2:0] are ignored (BL8 alignment). Higher bits alias (wrap modulo 2^DEPTH_BITS).
- Command FIFO: depth 4, entries {cmd, word index}.
  - Push when app_en && app_rdy.
  - app_rdy = calibrated && count < 4, from registered count.
  - Push and pop in the same cycle when full is not allowed, since app_rdy is already 0.
  - Commands other than read/write are accepted and discarded at execution, one cycle each.
- Data FIFO: depth 4, entries {data, mask}.
  - Push when app_wdf_wren && app_wdf_rdy.
  - app_wdf_rdy = calibrated && count < 4.
  - Data may arrive before, with, or after its write command.
- Executor: at most one command per cycle, in strict FIFO order.
  - Head read: executes immediately.
  - Head write: executes only when the data FIFO is non-empty. It pops both FIFOs and updates each byte whose mask bit is 0. Otherwise the executor stalls and the head is not bypassed.
  - Ordering guarantee: a read issued after a write to the same word returns the new data. A read issued before the write returns the old data.
- Read path: storage read plus a RD_LATENCY-stage valid/data pipeline. app_rd_data_valid = app_rd_data_end is a single-cycle pulse per read command. Back-to-back reads produce back-to-back valid pulses. There is no backpressure on read data.
- Protocol error: app_wdf_wren with app_wdf_end = 0 is accepted as a normal beat. The simulation-only assertion reports it.

Optional Feature:
- Macro APP_RESP_RANDOM_STALL_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) forces app_rdy and app_wdf_rdy low on cycles where lfsr[1:0] == 2'b00. This stresses handshake retry; ordering and data behaviour are unchanged.
- Undefined: no LFSR; ready signals follow FIFO occupancy only.

Test Plan:
1. Reset release, idle -> init_calib_complete rises exactly CALIB_CYCLES (64) cycles later. app_rdy/app_wdf_rdy are 0 before that and 1 after.
2. Write word 0x11..11 to app_addr 0x0008 (data with command), then read 0x0008 -> app_rd_data = 0x11..11 with valid exactly RD_LATENCY + 1 cycles after read acceptance (1 cycle to head execution with an empty FIFO).
3. Write command to 0x0010 with data sent 3 cycles later, read 0x0010 queued behind it -> read waits for the write; returns new data, not stale.
4. Write all-1s, then write 0 with mask = all-1s except bit 0, read back -> byte 0 = 0x00, all other bytes 0xFF.
5. Issue 5 back-to-back commands with no data -> app_rdy drops after 4 accepted. Supply data -> the FIFO drains one command per cycle and app_rdy returns.
6. Assert rst while 2 reads are in flight -> no app_rd_data_valid pulses. After re-calibration, a read of a previously written address returns the stored data.
